// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table evaluator: table width helper,
// FSM state encoding and the default function (matches the legacy 3-input cell).
package tt_pkg;

    function automatic int TT_W(input int n);
        return 1 << n;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [7:0] TT_DEFAULT = 8'h7E;

endpackage

// File: rtl/tt_cfg_shift.sv
// Serial truth-table loader: MSB-first shadow shift register, bit counter and
// a commit strobe asserted on the cycle that carries the final bit.
module tt_cfg_shift
    import tt_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    input  logic                  cfg_bit,
    output logic [TT_W(N_IN)-1:0] load_value,
    output logic                  commit,
    output logic                  busy
);

    localparam int TW = TT_W(N_IN);
    localparam logic [N_IN:0] CNT_LAST = (N_IN + 1)'(TW - 1);
    localparam logic [N_IN:0] CNT_ONE  = (N_IN + 1)'(1);

    // Only TW-1 bits need storing; the last bit arrives live with the commit.
    logic [TW-2:0] sh;
    logic [N_IN:0] cnt;

    assign load_value = {sh, cfg_bit};
    assign commit     = cfg_valid && (cnt == CNT_LAST);
    assign busy       = (cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (cfg_valid) begin
            sh  <= load_value[TW-2:0];
            cnt <= commit ? '0 : cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/truth_table_eval.sv
// Reprogrammable N-input Boolean function evaluator with a registered
// valid/ready output stage and a whole-table sweep mode.
module truth_table_eval
    import tt_pkg::*;
#(
    parameter int                   N_IN     = 3,
    parameter logic [TT_W(N_IN)-1:0] TT_RESET = TT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    input  logic            sweep_start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data,
    output logic [N_IN-1:0] out_index,
    output logic            out_last,
    output state_t          dbg_state
);

    localparam int TW = TT_W(N_IN);
    localparam logic [N_IN-1:0] ROW_LAST = '1;
    localparam logic [N_IN-1:0] ROW_ONE  = N_IN'(1);

    logic [TW-1:0]   tt;
    logic [TW-1:0]   cfg_value;
    logic            cfg_commit;
    state_t          state, state_next;
    logic [N_IN-1:0] row, row_next;
    logic            out_free;
    logic            load;
    logic            ld_data;
    logic            ld_last;
    logic [N_IN-1:0] ld_index;

    tt_cfg_shift #(.N_IN(N_IN)) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .load_value (cfg_value),
        .commit     (cfg_commit),
        .busy       (cfg_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt <= TT_RESET;
        end else if (cfg_commit) begin
            tt <= cfg_value;
        end
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The output register accepts a new value when empty or being drained.
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && !sweep_start && out_free;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        row_next   = row;
        load       = 1'b0;
        ld_data    = 1'b0;
        ld_index   = '0;
        ld_last    = 1'b0;
        case (state)
            IDLE: begin
                // A sweep request outranks a concurrent evaluation; row 0 is
                // issued immediately when the output stage has room.
                if (sweep_start) begin
                    state_next = SWEEP;
                    row_next   = '0;
                    if (out_free) begin
                        load     = 1'b1;
                        ld_data  = tt[0];
                        row_next = ROW_ONE;
                    end
                end else if (in_valid && out_free) begin
                    load     = 1'b1;
                    ld_data  = tt[in_data];
                    ld_index = in_data;
                end
            end
            SWEEP: begin
                if (out_free) begin
                    load     = 1'b1;
                    ld_data  = tt[row];
                    ld_index = row;
                    ld_last  = (row == ROW_LAST);
                    row_next = row + ROW_ONE;
                    if (row == ROW_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_next;
            row   <= row_next;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= ld_data;
                out_index <= ld_index;
                out_last  <= ld_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
